// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter: FSM states, master count and
// the index type used for grants, mux select and split ownership.
package bus_arb_pkg;

   localparam int NUM_MASTERS = 2;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } arb_state_t;

   typedef logic [$clog2(NUM_MASTERS)-1:0] master_idx_t;

   function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input master_idx_t idx);
      logic [NUM_MASTERS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters (master modport) and the
// arbiter (slave modport).
interface bus_arbiter_if;
   import bus_arb_pkg::*;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] done;
   logic                   split_req;
   logic                   split_done;
   logic [NUM_MASTERS-1:0] grant;
   master_idx_t            master_sel;
   logic                   bus_busy;
   logic                   split_en;
   logic                   timeout;

   modport master (
      output req, done, split_req, split_done,
      input  grant, master_sel, bus_busy, split_en, timeout
   );

   modport slave (
      input  req, done, split_req, split_done,
      output grant, master_sel, bus_busy, split_en, timeout
   );

endinterface

// File: rtl/bus_arbiter_timeout_counter.sv
// Bus-hold counter: cleared while the bus is idle, counts owner cycles and
// flags the cycle in which the owner has held the bus for TIMEOUT cycles.
module arb_timeout_counter #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count < LIMIT) begin
         count <= count + CNT_W'(1);
      end
   end

   // count holds the number of completed owner cycles, so LAST marks the final one
   assign expired = enable && (count >= LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with split-transaction support and a
// forced release when an owner holds the bus for TIMEOUT cycles.
module bus_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input logic          clk,
   input logic          rst,
   bus_arbiter_if.slave bus
);
   import bus_arb_pkg::*;

   arb_state_t             state, state_next;
   logic [NUM_MASTERS-1:0] grant, grant_next;
   master_idx_t            owner_sel, sel_next;
   master_idx_t            last_grant, last_next;
   master_idx_t            split_owner, split_owner_next;
   master_idx_t            pick;
   logic                   split_pending, pend_next;
   logic                   split_ready, ready_next;
   logic                   timeout_q, timeout_next;
   logic [NUM_MASTERS-1:0] split_mask, eligible;
   logic                   go, owner_done, expired;

   arb_timeout_counter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_IDLE),
      .enable  (state == ST_BUSY),
      .expired (expired)
   );

   // A split master that is still waiting on its slave must not win the bus
   always_comb begin
      split_mask = (split_pending && !split_ready) ? idx_to_onehot(split_owner) : '0;
      eligible   = bus.req & ~split_mask;
      owner_done = bus.done[owner_sel];
   end

   always_comb begin
      state_next       = state;
      grant_next       = grant;
      sel_next         = owner_sel;
      last_next        = last_grant;
      split_owner_next = split_owner;
      pend_next        = split_pending;
      ready_next       = split_ready;
      timeout_next     = 1'b0;
      pick             = '0;
      go               = 1'b0;

      if (split_pending && bus.split_done) begin
         ready_next = 1'b1;
      end

      unique case (state)
         ST_IDLE: begin
            if (split_pending && split_ready) begin
               go         = 1'b1;
               pick       = split_owner;
               pend_next  = 1'b0;
               ready_next = 1'b0;
            end else if (eligible == '1) begin
               go   = 1'b1;
               pick = ~last_grant;
            end else if (|eligible) begin
               go   = 1'b1;
               pick = eligible[1] ? master_idx_t'(1) : master_idx_t'(0);
            end
            if (go) begin
               state_next = ST_BUSY;
               grant_next = idx_to_onehot(pick);
               sel_next   = pick;
               last_next  = pick;
            end
         end
         ST_BUSY: begin
            // Release priority: done, then a new split, then the hold timeout
            if (owner_done) begin
               state_next = ST_IDLE;
               grant_next = '0;
            end else if (bus.split_req && !split_pending) begin
               state_next       = ST_IDLE;
               grant_next       = '0;
               pend_next        = 1'b1;
               split_owner_next = owner_sel;
            end else if (expired) begin
               state_next   = ST_IDLE;
               grant_next   = '0;
               timeout_next = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         grant         <= '0;
         owner_sel     <= '0;
         last_grant    <= master_idx_t'(1);
         split_owner   <= '0;
         split_pending <= 1'b0;
         split_ready   <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state         <= state_next;
         grant         <= grant_next;
         owner_sel     <= sel_next;
         last_grant    <= last_next;
         split_owner   <= split_owner_next;
         split_pending <= pend_next;
         split_ready   <= ready_next;
         timeout_q     <= timeout_next;
      end
   end

   assign bus.grant      = grant;
   assign bus.master_sel = owner_sel;
   assign bus.bus_busy   = |grant;
   assign bus.split_en   = split_pending;
   assign bus.timeout    = timeout_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles a master may hold the bus before forced release; legal range 2..255.
REQ-002 Parameter CNT_W, default 8: timeout counter width, sized so that TIMEOUT fits.
REQ-003 One clock; reset is synchronous and active-high. Clock is clk, reset is rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req  in  2  per-master bus request, level; bit i = master i.
REQ-007 done  in  2  per-master one-cycle end-of-transaction pulse; honoured only from current owner.
REQ-008 split_req  in  1  addressed slave requests split; owner releases bus.
REQ-009 split_done  in  1  split slave ready; split master resumes.
REQ-010 grant  out  2  one-hot bus grant, registered.
REQ-011 master_sel  out  1  bus mux select = index of owner; holds last owner when idle.
REQ-012 bus_busy  out  1  high while any grant bit is high.
REQ-013 split_en  out  1  high while a split is outstanding.
REQ-014 timeout  out  1  one-cycle pulse on forced release.

Function
REQ-015 FSM states: IDLE, BUSY; plus split_pending flag and split_owner register.
REQ-016 IDLE: eligible = req masked by (split_pending & ~split_ready) for split_owner; any eligible -> BUSY, grant registered next cycle (1-cycle request-to-grant latency).
REQ-017 Priority in IDLE: a resumed split master (split_ready) first; else round-robin, grant the master not last granted; both requesting alternate.
REQ-018 BUSY -> IDLE on done[owner], split_req, or counter reaching TIMEOUT; grant drops next cycle.
REQ-019 One mandatory turnaround cycle: a new grant is never issued in the cycle grant drops.
REQ-020 split_req in BUSY with no split pending: set split_pending, split_owner = owner, split_en = 1.
REQ-021 split_req while split already pending: ignored; owner keeps bus.
REQ-022 split_done with split_pending: set split_ready; on next IDLE grant split_owner (even if req low) and clear split_pending, split_ready, split_en.
REQ-023 split_done with no split pending: ignored.
REQ-024 Simultaneous done[owner] and split_req: done wins, no split recorded.
REQ-025 Simultaneous done[owner] and timeout: done wins, no timeout pulse.
REQ-026 Timeout counter clears on each grant, increments each BUSY cycle, saturates; forced release pulses timeout for one cycle.
REQ-027 done from non-owner or in IDLE: ignored.
REQ-028 grant is always one-hot or zero.

Reset
REQ-029 rst: state IDLE, grant 0, bus_busy 0, master_sel 0, split_en 0, timeout 0, counter 0, split state cleared, last-granted = 1 (master 0 wins first).
REQ-030 rst mid-transaction or mid-split aborts everything; first grant no earlier than one cycle after rst deasserts.

Structure
REQ-031 Package bus_arb_pkg holds: state enum, NUM_MASTERS = 2, master index typedef.
REQ-032 Sub-module arb_timeout_counter (clear, enable, CNT_W, TIMEOUT compare -> expired).

Verification
REQ-033 req=2'b01 at cycle 0 -> grant=2'b01 at cycle 1; done[0] at 5 -> grant=0 at 6.
REQ-034 req=2'b11 held, owners pulse done -> grants 01, 10, 01 with one idle cycle between.
REQ-035 Master 0 owns; split_req -> split_en=1, grant=0; req[1]=1 -> grant=10; done[1] then split_done -> grant=01, split_en=0.
REQ-036 TIMEOUT=4, owner never pulses done -> grant drops after 4 BUSY cycles, timeout pulses once.
REQ-037 done[0] and split_req same cycle -> split_en stays 0; rst asserted while BUSY -> all outputs 0 next cycle.
